// File: rtl/mod_wave_sequencer.sv
// Tone-burst sequencer: osc step strobes, phase clears, modulation count, start/busy/done.
// Latency: all outputs registered, one clock after the deciding input; no backpressure, start ignored while busy.
module mod_wave_sequencer #(
  parameter int CNT_W = 8,
  parameter int NB_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] rate_div,
  input  logic [CNT_W-1:0] half_period,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [CNT_W-1:0] gap_len,
  input  logic [NB_W-1:0]  num_bursts,
  output logic             osc_en,
  output logic             osc_clr,
  output logic [CNT_W-1:0] cout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_DONE} state_t;

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [NB_W-1:0]  NB_ONE = NB_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] psc_q, psc_d, step_q, step_d, half_q, half_d, gap_q, gap_d;
  logic [NB_W-1:0]  bidx_q, bidx_d;
  logic [CNT_W-1:0] rate_q, rate_d, hp_q, hp_d, bl_q, bl_d, gl_q, gl_d;
  logic [NB_W-1:0]  nb_q, nb_d;
  logic [CNT_W-1:0] cout_d;
  logic             en_d, clr_d, busy_d, done_d;
  logic             tick, new_burst;
  logic [CNT_W-1:0] half_eff, burst_eff;

  // zero encodes one for the step-based lengths
  assign half_eff  = (hp_q == '0) ? ONE : hp_q;
  assign burst_eff = (bl_q == '0) ? ONE : bl_q;
  assign tick      = (psc_q == rate_q);

  always_comb begin
    state_d   = state_q;
    psc_d     = psc_q;
    step_d    = step_q;
    half_d    = half_q;
    gap_d     = gap_q;
    bidx_d    = bidx_q;
    rate_d    = rate_q;
    hp_d      = hp_q;
    bl_d      = bl_q;
    gl_d      = gl_q;
    nb_d      = nb_q;
    cout_d    = cout;
    busy_d    = busy;
    clr_d     = 1'b0;
    done_d    = 1'b0;
    new_burst = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          rate_d    = rate_div;
          hp_d      = half_period;
          bl_d      = burst_len;
          gl_d      = gap_len;
          nb_d      = num_bursts;
          bidx_d    = '0;
          busy_d    = 1'b1;
          new_burst = 1'b1;
        end
      end
      S_ON: begin
        psc_d = tick ? '0 : psc_q + ONE;
        if (tick) begin
          step_d = step_q + ONE;
          if (half_q == half_eff - ONE) begin
            half_d = '0;
            cout_d = cout + ONE;
          end else begin
            half_d = half_q + ONE;
          end
          if (step_q == burst_eff - ONE) begin
            // nb_q - 1 wraps to all-ones, so a zero count runs 2**NB_W bursts
            if (bidx_q == nb_q - NB_ONE) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              bidx_d = bidx_q + NB_ONE;
              if (gl_q == '0) begin
                new_burst = 1'b1;
              end else begin
                state_d = S_OFF;
                gap_d   = '0;
              end
            end
          end
        end
      end
      S_OFF: begin
        psc_d = tick ? '0 : psc_q + ONE;
        if (tick) begin
          if (gap_q == gl_q - ONE) new_burst = 1'b1;
          else                     gap_d     = gap_q + ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (new_burst) begin
      state_d = S_ON;
      psc_d   = '0;
      step_d  = '0;
      half_d  = '0;
      cout_d  = '0;
      clr_d   = 1'b1;
    end

    if (stop) begin
      state_d = S_IDLE;
      psc_d   = '0;
      step_d  = '0;
      half_d  = '0;
      gap_d   = '0;
      bidx_d  = '0;
      cout_d  = '0;
      busy_d  = 1'b0;
      clr_d   = 1'b0;
      done_d  = 1'b0;
    end

    // strobe is registered, so it is predicted from the next-cycle prescaler
    en_d = (state_d == S_ON) && (psc_d == rate_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      psc_q   <= '0;
      step_q  <= '0;
      half_q  <= '0;
      gap_q   <= '0;
      bidx_q  <= '0;
      rate_q  <= '0;
      hp_q    <= '0;
      bl_q    <= '0;
      gl_q    <= '0;
      nb_q    <= '0;
      cout    <= '0;
      osc_en  <= 1'b0;
      osc_clr <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      psc_q   <= psc_d;
      step_q  <= step_d;
      half_q  <= half_d;
      gap_q   <= gap_d;
      bidx_q  <= bidx_d;
      rate_q  <= rate_d;
      hp_q    <= hp_d;
      bl_q    <= bl_d;
      gl_q    <= gl_d;
      nb_q    <= nb_d;
      cout    <= cout_d;
      osc_en  <= en_d;
      osc_clr <= clr_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_mod_wave_sequencer.sv
// Randomized bench for mod_wave_sequencer against a burst-level timing model.
module tb_mod_wave_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] rate_div = '0, half_period = '0, burst_len = '0, gap_len = '0;
  logic [3:0] num_bursts = '0;
  logic       osc_en, osc_clr, busy, done;
  logic [7:0] cout;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit en;
    bit clr;
    int cout;
    bit busy;
    bit done;
  } exp_t;

  mod_wave_sequencer #(.CNT_W(8), .NB_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .rate_div(rate_div), .half_period(half_period), .burst_len(burst_len),
    .gap_len(gap_len), .num_bursts(num_bursts),
    .osc_en(osc_en), .osc_clr(osc_clr), .cout(cout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cmp_item(input string nm, input int i, input exp_t e);
    check($sformatf("%s[%0d].osc_en", nm, i),  int'(osc_en),  int'(e.en));
    check($sformatf("%s[%0d].osc_clr", nm, i), int'(osc_clr), int'(e.clr));
    check($sformatf("%s[%0d].busy", nm, i),    int'(busy),    int'(e.busy));
    check($sformatf("%s[%0d].done", nm, i),    int'(done),    int'(e.done));
    check($sformatf("%s[%0d].cout", nm, i),    int'(cout),    e.cout);
  endtask

  task automatic check_quiet(input string nm, input bit with_cout);
    check({nm, ".osc_en"},  int'(osc_en),  0);
    check({nm, ".osc_clr"}, int'(osc_clr), 0);
    check({nm, ".busy"},    int'(busy),    0);
    check({nm, ".done"},    int'(done),    0);
    if (with_cout) check({nm, ".cout"}, int'(cout), 0);
  endtask

  task automatic drive_noise(input bit noise);
    if (noise) begin
      start       = 1'($urandom);
      rate_div    = 8'($urandom);
      half_period = 8'($urandom);
      burst_len   = 8'($urandom);
      gap_len     = 8'($urandom);
      num_bursts  = 4'($urandom);
    end
  endtask

  // abort_kind: 0 none, 1 stop after item abort_at, 2 reset during item abort_at
  task automatic run_seq(input string nm, input int r, input int h, input int b,
                         input int g, input int n, input bit noise,
                         input int abort_kind, input int abort_at);
    exp_t q[$];
    exp_t e;
    int rp, beff, heff, nbe, fin;
    rp   = r + 1;
    beff = (b == 0) ? 1 : b;
    heff = (h == 0) ? 1 : h;
    nbe  = (n == 0) ? 16 : n;
    fin  = (beff / heff) % 256;
    for (int bi = 0; bi < nbe; bi++) begin
      for (int j = 0; j < beff * rp; j++) begin
        e.en = ((j % rp) == rp - 1); e.clr = (j == 0);
        e.cout = ((j / rp) / heff) % 256; e.busy = 1'b1; e.done = 1'b0;
        q.push_back(e);
      end
      if (bi != nbe - 1) begin
        for (int j = 0; j < g * rp; j++) begin
          e.en = 1'b0; e.clr = 1'b0; e.cout = fin; e.busy = 1'b1; e.done = 1'b0;
          q.push_back(e);
        end
      end
    end
    e.en = 1'b0; e.clr = 1'b0; e.cout = fin; e.busy = 1'b0; e.done = 1'b1;
    q.push_back(e);

    rate_div = 8'(r); half_period = 8'(h); burst_len = 8'(b);
    gap_len = 8'(g); num_bursts = 4'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      cmp_item(nm, i, q[i]);
      if (abort_kind == 1 && i == abort_at) begin
        start = 1'b0;
        stop  = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        check_quiet({nm, ".stop"}, 1'b1);
        for (int k = 0; k < 20; k++) begin
          @(posedge clk); #1;
          check({nm, ".post_stop.done"}, int'(done), 0);
          check({nm, ".post_stop.busy"}, int'(busy), 0);
        end
        return;
      end
      if (abort_kind == 2 && i == abort_at) begin
        start = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_quiet({nm, ".rst"}, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
          @(posedge clk); #1;
          check({nm, ".post_rst.done"}, int'(done), 0);
          check({nm, ".post_rst.busy"}, int'(busy), 0);
        end
        return;
      end
      drive_noise(noise);
      @(posedge clk); #1;
    end
    start = 1'b0;
    check_quiet({nm, ".idle"}, 1'b0);
  endtask

  initial begin
    #1;
    check_quiet("reset", 1'b1);
    #11 rst = 1'b1;
    @(posedge clk); #1;
    check_quiet("reset_release", 1'b1);

    run_seq("t1", 0, 2, 8, 0, 1, 1'b0, 0, 0);
    run_seq("t2", 3, 1, 2, 1, 2, 1'b0, 0, 0);
    run_seq("t3", 0, 1, 10, 0, 1, 1'b0, 1, 3);
    run_seq("t4", 2, 3, 5, 2, 3, 1'b1, 0, 0);

    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    check_quiet("start_stop", 1'b1);
    @(posedge clk); #1;
    check_quiet("start_stop_2", 1'b1);

    run_seq("t5", 3, 1, 2, 1, 2, 1'b0, 2, 9);
    run_seq("t5b", 0, 2, 8, 0, 1, 1'b0, 0, 0);
    run_seq("t6", 0, 0, 0, 0, 0, 1'b0, 0, 0);

    for (int t = 0; t < 20; t++) begin
      int kind;
      kind = ($urandom_range(0, 3) == 0) ? 1 : 0;
      run_seq($sformatf("rnd%0d", t),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
              int'($urandom_range(0, 12)), int'($urandom_range(0, 5)),
              int'($urandom_range(0, 3)), 1'b1, kind, int'($urandom_range(0, 40)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
